// File: rtl/cpu16_pkg.sv
// Shared encodings for the 16-bit CPU control path: opcodes, FSM states, ALUOp and ALUSrcB codes.
package cpu16_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned COUNT_W  = 16;

  localparam logic [OPCODE_W-1:0] OP_R0    = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_R1    = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SHIFT = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_LW    = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_SW    = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_SUBI  = 4'b1010;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 4'b1011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BEQ = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_e;

  typedef struct packed {
    logic is_r;
    logic is_i;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode-to-instruction-class decode shared by next-state and RegDst logic.
module opcode_classifier
  import cpu16_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output op_class_t           cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_R0, OP_R1:                      cls_o.is_r   = 1'b1;
      OP_SHIFT, OP_ADDI, OP_SUBI, OP_SLTI: cls_o.is_i = 1'b1;
      OP_LW:                             cls_o.is_lw  = 1'b1;
      OP_SW:                             cls_o.is_sw  = 1'b1;
      OP_BEQ:                            cls_o.is_beq = 1'b1;
      default:                           cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath enables and ALUOp, and counts retired instructions.
module main_control_fsm
  import cpu16_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic [1:0]          Funct,
  input  logic                Zero,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                PCSource,
  output logic                IllegalOp,
  output logic [STATE_W-1:0]  State,
  output logic [COUNT_W-1:0]  InstrCount
);

  state_e             state_q;
  logic               illegal_q;
  logic [COUNT_W-1:0] count_q;
  op_class_t          cls;

  // Both R-format opcodes write rd, so Funct never changes the destination choice.
  logic unused_funct;
  assign unused_funct = ^Funct;

  opcode_classifier u_classifier (
    .opcode_i (Opcode),
    .cls_o    (cls)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (MemReady) state_q <= S_DECODE;
        S_DECODE: begin
          if (cls.is_r)                  state_q <= S_EXEC_R;
          else if (cls.is_i)             state_q <= S_EXEC_I;
          else if (cls.is_lw || cls.is_sw) state_q <= S_ADDR;
          else if (cls.is_beq)           state_q <= S_BRANCH;
          else begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC_R, S_EXEC_I: state_q <= S_WB_ALU;
        S_ADDR:   state_q <= cls.is_lw ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: if (MemReady) state_q <= S_WB_MEM;
        S_MEM_WR: begin
          if (MemReady) begin
            state_q <= S_FETCH;
            count_q <= count_q + COUNT_W'(1);
          end
        end
        S_WB_ALU, S_WB_MEM, S_BRANCH: begin
          state_q <= S_FETCH;
          count_q <= count_q + COUNT_W'(1);
        end
        S_TRAP:   state_q <= S_TRAP;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the current state; only PCWrite/IRWrite see MemReady/Zero directly.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REGB;
    ALUOp    = ALUOP_ADD;
    PCSource = 1'b0;
    if (!Reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_TWO;
          PCWrite = MemReady;
          IRWrite = MemReady;
        end
        S_DECODE: ALUSrcB = SRCB_IMM_SH;
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_R;
        end
        S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_I;
        end
        S_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEM_RD: MemRead  = 1'b1;
        S_MEM_WR: MemWrite = 1'b1;
        S_WB_ALU: begin
          RegWrite = 1'b1;
          RegDst   = cls.is_r;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALUOP_BEQ;
          PCSource = 1'b1;
          PCWrite  = Zero;
        end
        default: ;
      endcase
    end
  end

  assign State      = state_q;
  assign IllegalOp  = illegal_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: steps instruction sequences and checks state,
// control vector and retire count against hand-computed values.
module tb_main_control_fsm;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Opcode = 4'b0001;
  logic [1:0]  Funct = 2'b00;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b1;
  logic        PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp;
  logic        PCSource, IllegalOp;
  logic [3:0]  State;
  logic [15:0] InstrCount;
  logic [13:0] ctl_obs;

  int n_pass  = 0;
  int n_total = 0;

  main_control_fsm dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .IllegalOp(IllegalOp), .State(State), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  // pcw irw mr mw rw rd m2r asa asb aop pcs ill
  assign ctl_obs = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
                    ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

  localparam logic [13:0] C_IDLE   = 14'b0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [13:0] C_FETCH  = 14'b1_1_1_0_0_0_0_0_01_00_0_0;
  localparam logic [13:0] C_FWAIT  = 14'b0_0_1_0_0_0_0_0_01_00_0_0;
  localparam logic [13:0] C_DECODE = 14'b0_0_0_0_0_0_0_0_11_00_0_0;
  localparam logic [13:0] C_EXEC_R = 14'b0_0_0_0_0_0_0_1_00_10_0_0;
  localparam logic [13:0] C_EXEC_I = 14'b0_0_0_0_0_0_0_1_10_11_0_0;
  localparam logic [13:0] C_ADDR   = 14'b0_0_0_0_0_0_0_1_10_00_0_0;
  localparam logic [13:0] C_MEM_RD = 14'b0_0_1_0_0_0_0_0_00_00_0_0;
  localparam logic [13:0] C_MEM_WR = 14'b0_0_0_1_0_0_0_0_00_00_0_0;
  localparam logic [13:0] C_WB_R   = 14'b0_0_0_0_1_1_0_0_00_00_0_0;
  localparam logic [13:0] C_WB_I   = 14'b0_0_0_0_1_0_0_0_00_00_0_0;
  localparam logic [13:0] C_WB_MEM = 14'b0_0_0_0_1_0_1_0_00_00_0_0;
  localparam logic [13:0] C_BR_T   = 14'b1_0_0_0_0_0_0_1_00_01_1_0;
  localparam logic [13:0] C_BR_NT  = 14'b0_0_0_0_0_0_0_1_00_01_1_0;
  localparam logic [13:0] C_TRAP   = 14'b0_0_0_0_0_0_0_0_00_00_0_1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive inputs in the low phase, then let combinational outputs settle.
  task automatic drv(input logic rst, input logic [3:0] op, input logic mr, input logic z);
    @(negedge Clock);
    Reset = rst; Opcode = op; MemReady = mr; Zero = z;
    #1;
  endtask

  task automatic ex(input string tag, input logic [3:0] st, input logic [13:0] ctl,
                    input logic [15:0] cnt);
    chk({tag, ".state"}, 16'(State), 16'(st));
    chk({tag, ".ctl"}, 16'(ctl_obs), 16'(ctl));
    chk({tag, ".cnt"}, InstrCount, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    drv(1, 4'b0001, 1, 0); ex("reset", 4'd0, C_IDLE, 16'd0);

    // ADD
    drv(0, 4'b0001, 1, 0); ex("add.fetch", 4'd0, C_FETCH, 16'd0);
    drv(0, 4'b0001, 1, 0); ex("add.decode", 4'd1, C_DECODE, 16'd0);
    drv(0, 4'b0001, 1, 0); ex("add.exec", 4'd2, C_EXEC_R, 16'd0);
    drv(0, 4'b0001, 1, 0); ex("add.wb", 4'd7, C_WB_R, 16'd0);

    // LW with two wait cycles in MEM_RD
    drv(0, 4'b0100, 1, 0); ex("lw.fetch", 4'd0, C_FETCH, 16'd1);
    drv(0, 4'b0100, 1, 0); ex("lw.decode", 4'd1, C_DECODE, 16'd1);
    drv(0, 4'b0100, 1, 0); ex("lw.addr", 4'd4, C_ADDR, 16'd1);
    drv(0, 4'b0100, 0, 0); ex("lw.rd0", 4'd5, C_MEM_RD, 16'd1);
    drv(0, 4'b0100, 0, 0); ex("lw.rd1", 4'd5, C_MEM_RD, 16'd1);
    drv(0, 4'b0100, 1, 0); ex("lw.rd2", 4'd5, C_MEM_RD, 16'd1);
    drv(0, 4'b0100, 1, 0); ex("lw.wb", 4'd8, C_WB_MEM, 16'd1);

    // BEQ taken, with one fetch stall
    drv(0, 4'b0110, 0, 1); ex("beq.fwait", 4'd0, C_FWAIT, 16'd2);
    drv(0, 4'b0110, 1, 0); ex("beq.fetch", 4'd0, C_FETCH, 16'd2);
    drv(0, 4'b0110, 0, 0); ex("beq.decode", 4'd1, C_DECODE, 16'd2);
    drv(0, 4'b0110, 1, 1); ex("beq.taken", 4'd9, C_BR_T, 16'd2);

    // BEQ not taken
    drv(0, 4'b0110, 1, 0); ex("beqn.fetch", 4'd0, C_FETCH, 16'd3);
    drv(0, 4'b0110, 1, 0); ex("beqn.decode", 4'd1, C_DECODE, 16'd3);
    drv(0, 4'b0110, 1, 0); ex("beqn.branch", 4'd9, C_BR_NT, 16'd3);

    // ADDI
    drv(0, 4'b1001, 1, 0); ex("addi.fetch", 4'd0, C_FETCH, 16'd4);
    drv(0, 4'b1001, 1, 0); ex("addi.decode", 4'd1, C_DECODE, 16'd4);
    drv(0, 4'b1001, 1, 0); ex("addi.exec", 4'd3, C_EXEC_I, 16'd4);
    drv(0, 4'b1001, 1, 0); ex("addi.wb", 4'd7, C_WB_I, 16'd4);

    // SW interrupted by reset while stalled in MEM_WR
    drv(0, 4'b0101, 1, 0); ex("swr.fetch", 4'd0, C_FETCH, 16'd5);
    drv(0, 4'b0101, 1, 0); ex("swr.decode", 4'd1, C_DECODE, 16'd5);
    drv(0, 4'b0101, 1, 0); ex("swr.addr", 4'd4, C_ADDR, 16'd5);
    drv(0, 4'b0101, 0, 0); ex("swr.wr", 4'd6, C_MEM_WR, 16'd5);
    drv(1, 4'b0101, 0, 0); ex("swr.reset", 4'd0, C_IDLE, 16'd0);

    // SW complete
    drv(0, 4'b0101, 1, 0); ex("sw.fetch", 4'd0, C_FETCH, 16'd0);
    drv(0, 4'b0101, 1, 0); ex("sw.decode", 4'd1, C_DECODE, 16'd0);
    drv(0, 4'b0101, 1, 0); ex("sw.addr", 4'd4, C_ADDR, 16'd0);
    drv(0, 4'b0101, 1, 0); ex("sw.wr", 4'd6, C_MEM_WR, 16'd0);

    // Illegal opcode traps and stays trapped
    drv(0, 4'b1111, 1, 0); ex("ill.fetch", 4'd0, C_FETCH, 16'd1);
    drv(0, 4'b1111, 1, 0); ex("ill.decode", 4'd1, C_DECODE, 16'd1);
    for (int i = 0; i < 20; i++) begin
      drv(0, 4'b0001, i[0], i[1]); ex("ill.trap", 4'd10, C_TRAP, 16'd1);
    end
    drv(1, 4'b0001, 1, 0); ex("ill.reset", 4'd0, C_IDLE, 16'd0);

    // Counter wrap on the next retire
    drv(0, 4'b0101, 1, 0); ex("wrap.fetch", 4'd0, C_FETCH, 16'd0);
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    #1;
    chk("wrap.preload", InstrCount, 16'hFFFF);
    drv(0, 4'b0101, 1, 0); ex("wrap.decode", 4'd1, C_DECODE, 16'hFFFF);
    drv(0, 4'b0101, 1, 0); ex("wrap.addr", 4'd4, C_ADDR, 16'hFFFF);
    drv(0, 4'b0101, 1, 0); ex("wrap.wr", 4'd6, C_MEM_WR, 16'hFFFF);
    drv(0, 4'b0001, 1, 0); ex("wrap.done", 4'd0, C_FETCH, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main control unit for the 16-bit CPU. It sequences every instruction through fetch, decode, execute, memory and write-back. It drives the datapath enables and the 2-bit ALUOp consumed by ALUcontrol_unit, which sits directly downstream. Opcode and Funct come from the instruction register, Zero comes from the ALU, and MemReady comes from the memory port.

## Interface
- No parameters; all encodings are fixed constants in the shared package.
- Clock  in  1  sole clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- Opcode  in  4  IR[15:12]; stable from DECODE until next FETCH completes
- Funct  in  2  IR[1:0]; used only for RegDst selection
- Zero  in  1  ALU zero flag, valid in BRANCH
- MemReady  in  1  memory completes the current read/write this cycle
- PCWrite, IRWrite, MemRead, MemWrite, RegWrite  out  1 each  datapath enables
- RegDst  out  1  1 = rd (R-format), 0 = rt
- MemtoReg  out  1  1 = memory data to register file
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = reg B, 01 = constant 2, 10 = sign-ext imm, 11 = sign-ext imm<<1
- ALUOp  out  2  00 add, 01 BEQ compare, 10 R-format, 11 I-format (to ALUcontrol_unit)
- PCSource  out  1  0 = ALU result, 1 = ALUOut (branch target)
- IllegalOp  out  1  sticky trap flag
- State  out  4  current state code, debug
- InstrCount  out  16  retired-instruction counter

## Operation
- Opcode classes:
  - R: 0000, 0001
  - I: 0010 (shifts), 1001 ADDI, 1010 SUBI, 1011 SLTI
  - LW 0100, SW 0101, BEQ 0110
  - all others illegal
- Moore FSM; outputs not listed for a state are 0.
- FETCH (0): MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - PCWrite=IRWrite=MemReady.
  - Stay while !MemReady; go to DECODE when MemReady.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target).
  - Next state by class: R→EXEC_R, I→EXEC_I, LW/SW→ADDR, BEQ→BRANCH, illegal→TRAP.
- EXEC_R (2): ALUSrcA=1, ALUSrcB=00, ALUOp=10 → WB_ALU.
- EXEC_I (3): ALUSrcA=1, ALUSrcB=10, ALUOp=11 → WB_ALU.
- ADDR (4): ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEM_RD for LW, MEM_WR for SW.
- MEM_RD (5): MemRead=1; hold until MemReady, then → WB_MEM.
- MEM_WR (6): MemWrite=1; hold until MemReady, then → FETCH (retire).
- WB_ALU (7): RegWrite=1, MemtoReg=0, RegDst=1 if R class else 0 → FETCH (retire).
- WB_MEM (8): RegWrite=1, MemtoReg=1, RegDst=0 → FETCH (retire).
- BRANCH (9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=Zero → FETCH (retire).
- TRAP (10): IllegalOp=1; all enables 0; remains in TRAP until Reset.
- InstrCount increments by 1 on every retire transition.
  - Wraps 0xFFFF→0x0000.
  - Never increments on entry to TRAP.

## Timing
- Reset asserted (any time, including mid-instruction or mid-stall):
  - State→FETCH, IllegalOp=0, InstrCount=0 immediately.
  - While Reset is high, all enables and ALUOp/ALUSrc*/PCSource/RegDst/MemtoReg are forced 0 (no fetch issued).
- First FETCH outputs appear in the first cycle after Reset deasserts.
- Instruction latencies, with zero-wait memory:
  - R/I: 4 cycles
  - BEQ: 3 cycles
  - SW: 4 cycles
  - LW: 5 cycles
- Each MemReady-low cycle in FETCH/MEM_RD/MEM_WR adds one cycle.
- MemReady is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored elsewhere.
- Zero is sampled only in BRANCH, combinationally into PCWrite.
- Opcode is decoded only in DECODE, ADDR and WB_ALU; changes elsewhere have no effect.
- No combinational path from MemReady/Zero to State; only to PCWrite/IRWrite.

## Structure
- Shared package cpu16_pkg holds:
  - opcode constants
  - state encoding (4-bit, values above)
  - ALUOp codes
  - ALUSrcB codes
- The package is shared with ALUcontrol_unit so the ALUOp encodings match.
- One sub-module, opcode_classifier: combinational Opcode→{is_r, is_i, is_lw, is_sw, is_beq, illegal}. It is reused by the FSM next-state logic and the WB_ALU RegDst selection.

## Test plan
- Reset then ADD (0001), MemReady=1 always → states 0,1,2,7,0; ALUOp=10 in state 2; RegWrite=1, RegDst=1 in state 7; InstrCount=1.
- LW (0100) with MemReady low 2 cycles in MEM_RD → MemRead held 3 cycles; WB_MEM has MemtoReg=1; total 7 cycles; InstrCount +1.
- BEQ (0110): Zero=1 → PCWrite=1, PCSource=1 in state 9. Repeat with Zero=0 → PCWrite=0; both retire in 3 cycles.
- ADDI (1001) → ALUOp=11, ALUSrcB=10 in EXEC_I; RegDst=0 in WB_ALU. Opcode 1111 → TRAP, IllegalOp=1 held 20 cycles, InstrCount unchanged.
- Reset pulsed mid-MEM_WR with MemWrite=1 → MemWrite drops immediately; State=0, InstrCount=0, IllegalOp cleared.
- Preload with 65535 retires (or force) then one more SW → InstrCount wraps to 0x0000.
